// File: rtl/vedio_pkg.sv
// Shared definitions for the video capture packer.
//   cap_state_t      : capture FSM states
//   ORDER_*          : channel ordering encodings for CHN_ORDER
//   cnt_width(n)     : bits needed to hold 0..n inclusive (min 1)
//   idx_width(n)     : bits needed to index 0..n-1 (min 1)
package vedio_pkg;

  typedef enum logic [0:0] {
    S_SYNC   = 1'b0,
    S_ACTIVE = 1'b1
  } cap_state_t;

  localparam int ORDER_MSB_FIRST = 0;
  localparam int ORDER_LSB_FIRST = 1;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vedio_edge_det.sv
// Registered rise/fall detector.
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : input level
//   rise, fall : single-cycle edge flags, valid in the cycle din changes
//   din_dly    : din delayed by one clock
module vedio_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall,
  output logic din_dly
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_dly <= 1'b0;
    end else begin
      din_dly <= din;
    end
  end

  // Edge flags compare the live input with last cycle's level so a
  // decision can be taken in the same cycle the edge arrives.
  assign rise = din & ~din_dly;
  assign fall = ~din & din_dly;

endmodule

// File: rtl/vedio_cap_pack.sv
// Video capture packer: gathers SRC_CHN channel bytes per pixel into one
// word, tracks pixel column/row and flags malformed lines and frames.
//   pclk, rst_n  : pixel clock, asynchronous active-low reset
//   src_hsync    : byte valid
//   src_vsync    : frame sync, rising edge starts a frame
//   src_data_out : channel byte
//   cap_hsync    : one-cycle strobe per packed pixel
//   cap_vsync    : src_vsync delayed one cycle
//   cap_data_out : packed pixel
//   cap_x, cap_y : pixel column and row
//   cap_sof      : first pixel of a frame
//   err_line     : malformed line pulse
//   err_frame    : malformed frame pulse
module vedio_cap_pack
  import vedio_pkg::*;
#(
  parameter  int IW        = 640,
  parameter  int IH        = 480,
  parameter  int SRC_DW    = 8,
  parameter  int SRC_CHN   = 3,
  parameter  int CHN_ORDER = 0,
  localparam int CAP_DW    = SRC_DW * SRC_CHN,
  localparam int XW        = cnt_width(IW),
  localparam int YW        = cnt_width(IH)
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              src_hsync,
  input  logic              src_vsync,
  input  logic [SRC_DW-1:0] src_data_out,
  output logic              cap_hsync,
  output logic              cap_vsync,
  output logic [CAP_DW-1:0] cap_data_out,
  output logic [XW-1:0]     cap_x,
  output logic [YW-1:0]     cap_y,
  output logic              cap_sof,
  output logic              err_line,
  output logic              err_frame
);

  localparam int            CW       = idx_width(SRC_CHN);
  localparam logic [CW-1:0] LAST_CHN = CW'(SRC_CHN - 1);
  localparam logic [XW-1:0] X_END    = XW'(IW);
  localparam logic [YW-1:0] Y_END    = YW'(IH);

  cap_state_t        state_reg;
  logic [CW-1:0]     chn_cnt_reg;
  logic [XW-1:0]     x_cnt_reg;
  logic [YW-1:0]     y_cnt_reg;
  logic              line_err_reg;
  logic [SRC_DW-1:0] chn_buf_reg [SRC_CHN];

  logic              cap_hsync_reg;
  logic [CAP_DW-1:0] cap_data_reg;
  logic [XW-1:0]     cap_x_reg;
  logic [YW-1:0]     cap_y_reg;
  logic              cap_sof_reg;
  logic              err_line_reg;
  logic              err_frame_reg;

  logic              hs_rise;
  logic              hs_fall;
  logic              hs_dly;
  logic              vs_rise;
  logic              vs_fall;
  logic              vs_dly;
  logic              take_byte;
  logic [CAP_DW-1:0] pack_next;

  vedio_edge_det u_hs_edge (
    .clk     (pclk),
    .rst_n   (rst_n),
    .din     (src_hsync),
    .rise    (hs_rise),
    .fall    (hs_fall),
    .din_dly (hs_dly)
  );

  vedio_edge_det u_vs_edge (
    .clk     (pclk),
    .rst_n   (rst_n),
    .din     (src_vsync),
    .rise    (vs_rise),
    .fall    (vs_fall),
    .din_dly (vs_dly)
  );

  // A byte counts only in an active frame with rows left; a frame-sync
  // edge in the same cycle wins and the byte is thrown away.
  assign take_byte = (state_reg == S_ACTIVE) && !vs_rise && src_hsync &&
                     (y_cnt_reg != Y_END);

  // Earlier channels come from the holding buffer, the last one straight
  // from the input so the pixel leaves one cycle after its final byte.
  genvar gi;
  for (gi = 0; gi < SRC_CHN; gi++) begin : g_pack
    logic [SRC_DW-1:0] chn_byte;
    if (gi == SRC_CHN - 1) begin : g_last
      assign chn_byte = src_data_out;
    end else begin : g_held
      assign chn_byte = chn_buf_reg[gi];
    end
    if (CHN_ORDER == ORDER_LSB_FIRST) begin : g_lsb
      assign pack_next[gi*SRC_DW +: SRC_DW] = chn_byte;
    end else begin : g_msb
      assign pack_next[(SRC_CHN-1-gi)*SRC_DW +: SRC_DW] = chn_byte;
    end
  end

  always_ff @(posedge pclk) begin
    if (take_byte) begin
      chn_buf_reg[chn_cnt_reg] <= src_data_out;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_SYNC;
      chn_cnt_reg   <= '0;
      x_cnt_reg     <= '0;
      y_cnt_reg     <= '0;
      line_err_reg  <= 1'b0;
      cap_hsync_reg <= 1'b0;
      cap_data_reg  <= '0;
      cap_x_reg     <= '0;
      cap_y_reg     <= '0;
      cap_sof_reg   <= 1'b0;
      err_line_reg  <= 1'b0;
      err_frame_reg <= 1'b0;
    end else begin
      cap_hsync_reg <= 1'b0;
      cap_sof_reg   <= 1'b0;
      err_line_reg  <= 1'b0;
      err_frame_reg <= 1'b0;
      case (state_reg)
        S_SYNC: begin
          if (vs_rise) begin
            state_reg    <= S_ACTIVE;
            chn_cnt_reg  <= '0;
            x_cnt_reg    <= '0;
            y_cnt_reg    <= '0;
            line_err_reg <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (vs_rise) begin
            err_frame_reg <= (y_cnt_reg != Y_END);
            chn_cnt_reg   <= '0;
            x_cnt_reg     <= '0;
            y_cnt_reg     <= '0;
            line_err_reg  <= 1'b0;
          end else if (hs_fall) begin
            if (y_cnt_reg == Y_END) begin
              // Surplus line beyond the last row: a frame-level fault.
              err_frame_reg <= 1'b1;
            end else begin
              err_line_reg <= (chn_cnt_reg != '0) || (x_cnt_reg != X_END) ||
                              line_err_reg;
              y_cnt_reg    <= y_cnt_reg + 1'b1;
            end
            chn_cnt_reg  <= '0;
            x_cnt_reg    <= '0;
            line_err_reg <= 1'b0;
          end else if (take_byte) begin
            if (chn_cnt_reg == LAST_CHN) begin
              chn_cnt_reg <= '0;
              if (x_cnt_reg < X_END) begin
                cap_hsync_reg <= 1'b1;
                cap_data_reg  <= pack_next;
                cap_x_reg     <= x_cnt_reg;
                cap_y_reg     <= y_cnt_reg;
                cap_sof_reg   <= (x_cnt_reg == '0) && (y_cnt_reg == '0);
                x_cnt_reg     <= x_cnt_reg + 1'b1;
              end else begin
                line_err_reg <= 1'b1;
              end
            end else begin
              chn_cnt_reg <= chn_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= S_SYNC;
      endcase
    end
  end

  assign cap_hsync    = cap_hsync_reg;
  assign cap_vsync    = vs_dly;
  assign cap_data_out = cap_data_reg;
  assign cap_x        = cap_x_reg;
  assign cap_y        = cap_y_reg;
  assign cap_sof      = cap_sof_reg;
  assign err_line     = err_line_reg;
  assign err_frame    = err_frame_reg;

endmodule

// File: tb/tb_vedio_cap_pack.sv
// Scoreboard bench for vedio_cap_pack. Three instances:
//   dut 0 : defaults (640x480, 3 channels, first channel in MSBs)
//   dut 1 : 4x2, 3 channels, first channel in LSBs
//   dut 2 : 4x2, 1 channel (pass-through)
// The stimulus process pushes expected events (pixel, line error, frame
// error) tagged with the cycle they must appear in; the monitor pops and
// compares whenever any instance raises an output event.
module tb_vedio_cap_pack;

  localparam int K_PIX    = 0;
  localparam int K_ELINE  = 1;
  localparam int K_EFRAME = 2;

  typedef struct {
    int          d;
    int          kind;
    logic [31:0] data;
    int          x;
    int          y;
    bit          sof;
    int          cyc;
  } ev_t;

  logic        pclk = 1'b0;
  logic [2:0]  rst_n;
  logic [2:0]  hs;
  logic [2:0]  vs;
  logic [7:0]  din [3];

  logic        a_hs, a_vs, a_sof, a_el, a_ef;
  logic [23:0] a_data;
  logic [9:0]  a_x;
  logic [8:0]  a_y;
  logic        b_hs, b_vs, b_sof, b_el, b_ef;
  logic [23:0] b_data;
  logic [2:0]  b_x;
  logic [1:0]  b_y;
  logic        c_hs, c_vs, c_sof, c_el, c_ef;
  logic [7:0]  c_data;
  logic [2:0]  c_x;
  logic [1:0]  c_y;

  logic [2:0]  m_hs, m_vs, m_sof, m_el, m_ef;
  logic [31:0] m_data [3];
  logic [15:0] m_x [3];
  logic [15:0] m_y [3];

  ev_t         exp_q[$];
  logic [31:0] tbl [8];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  bit          done = 1'b0;
  logic [2:0]  vs_d1 = '0;
  logic [2:0]  vs_d2 = '0;
  logic [2:0]  rst_d1 = '0;

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    cyc    <= cyc + 1;
    vs_d1  <= vs;
    vs_d2  <= vs_d1;
    rst_d1 <= rst_n;
  end

  vedio_cap_pack u_dut_a (
    .pclk(pclk), .rst_n(rst_n[0]), .src_hsync(hs[0]), .src_vsync(vs[0]),
    .src_data_out(din[0]), .cap_hsync(a_hs), .cap_vsync(a_vs),
    .cap_data_out(a_data), .cap_x(a_x), .cap_y(a_y), .cap_sof(a_sof),
    .err_line(a_el), .err_frame(a_ef)
  );

  vedio_cap_pack #(.IW(4), .IH(2), .SRC_DW(8), .SRC_CHN(3), .CHN_ORDER(1)) u_dut_b (
    .pclk(pclk), .rst_n(rst_n[1]), .src_hsync(hs[1]), .src_vsync(vs[1]),
    .src_data_out(din[1]), .cap_hsync(b_hs), .cap_vsync(b_vs),
    .cap_data_out(b_data), .cap_x(b_x), .cap_y(b_y), .cap_sof(b_sof),
    .err_line(b_el), .err_frame(b_ef)
  );

  vedio_cap_pack #(.IW(4), .IH(2), .SRC_DW(8), .SRC_CHN(1), .CHN_ORDER(0)) u_dut_c (
    .pclk(pclk), .rst_n(rst_n[2]), .src_hsync(hs[2]), .src_vsync(vs[2]),
    .src_data_out(din[2]), .cap_hsync(c_hs), .cap_vsync(c_vs),
    .cap_data_out(c_data), .cap_x(c_x), .cap_y(c_y), .cap_sof(c_sof),
    .err_line(c_el), .err_frame(c_ef)
  );

  assign m_hs  = {c_hs,  b_hs,  a_hs};
  assign m_vs  = {c_vs,  b_vs,  a_vs};
  assign m_sof = {c_sof, b_sof, a_sof};
  assign m_el  = {c_el,  b_el,  a_el};
  assign m_ef  = {c_ef,  b_ef,  a_ef};
  assign m_data[0] = {8'h00, a_data};
  assign m_data[1] = {8'h00, b_data};
  assign m_data[2] = {24'h0, c_data};
  assign m_x[0] = {6'h0, a_x};
  assign m_x[1] = {13'h0, b_x};
  assign m_x[2] = {13'h0, c_x};
  assign m_y[0] = {7'h0, a_y};
  assign m_y[1] = {14'h0, b_y};
  assign m_y[2] = {14'h0, c_y};

  // ---------------- stimulus helpers ----------------
  task automatic drv(input int d, input bit h, input bit v, input logic [7:0] dat);
    hs[d]  = h;
    vs[d]  = v;
    din[d] = dat;
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) drv(d, 1'b0, vs[d], 8'h00);
  endtask

  task automatic exp_pix(input int d, input logic [31:0] data, input int x,
                         input int y, input bit sof);
    ev_t e;
    e.d = d; e.kind = K_PIX; e.data = data; e.x = x; e.y = y; e.sof = sof;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic exp_err(input int d, input int kind);
    ev_t e;
    e.d = d; e.kind = kind; e.data = '0; e.x = 0; e.y = 0; e.sof = 1'b0;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic vs_pulse(input int d);
    drv(d, 1'b0, 1'b1, 8'h00);
    drv(d, 1'b0, 1'b1, 8'h00);
    drv(d, 1'b0, 1'b0, 8'h00);
  endtask

  // Bytes first, first+1, ...; pixel k of the line carries tbl[k].
  task automatic send_line(input int d, input int n, input int first,
                           input int chn, input int iw, input int y);
    for (int i = 0; i < n; i++) begin
      if ((i % chn) == chn - 1 && (i / chn) < iw)
        exp_pix(d, tbl[i / chn], i / chn, y, (y == 0) && (i / chn == 0));
      drv(d, 1'b1, vs[d], 8'(first + i));
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check_event(input int d, input int k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event dut%0d: got kind=%0d data=%h x=%0d y=%0d at cyc %0d, required no event",
               d, k, m_data[d], m_x[d], m_y[d], cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.d != d || e.kind != k || e.cyc != cyc ||
        (k == K_PIX && (e.data != m_data[d] || e.x != int'(m_x[d]) ||
                        e.y != int'(m_y[d]) || e.sof != m_sof[d]))) begin
      fails++;
      $display("FAIL event dut%0d: got kind=%0d data=%h x=%0d y=%0d sof=%0b cyc=%0d, required dut%0d kind=%0d data=%h x=%0d y=%0d sof=%0b cyc=%0d",
               d, k, m_data[d], m_x[d], m_y[d], m_sof[d], cyc,
               e.d, e.kind, e.data, e.x, e.y, e.sof, e.cyc);
    end else begin
      $display("ok   dut%0d kind=%0d data=%h x=%0d y=%0d sof=%0b cyc=%0d",
               d, k, m_data[d], m_x[d], m_y[d], m_sof[d], cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge pclk);
      for (int d = 0; d < 3; d++) begin
        if (!rst_n[d]) begin
          checks++;
          if (m_hs[d] || m_vs[d] || m_sof[d] || m_el[d] || m_ef[d] ||
              m_data[d] != 0 || m_x[d] != 0 || m_y[d] != 0) begin
            fails++;
            $display("FAIL reset_state dut%0d: got hs=%0b vs=%0b sof=%0b el=%0b ef=%0b data=%h x=%0d y=%0d, required all zero",
                     d, m_hs[d], m_vs[d], m_sof[d], m_el[d], m_ef[d], m_data[d], m_x[d], m_y[d]);
          end
        end else begin
          if (rst_d1[d] && (vs_d1[d] != vs_d2[d])) begin
            checks++;
            if (m_vs[d] !== vs_d1[d]) begin
              fails++;
              $display("FAIL cap_vsync dut%0d cyc %0d: got %0b, required %0b",
                       d, cyc, m_vs[d], vs_d1[d]);
            end
          end
          if (m_hs[d]) check_event(d, K_PIX);
          if (m_el[d]) check_event(d, K_ELINE);
          if (m_ef[d]) check_event(d, K_EFRAME);
        end
      end
      if (done) begin
        checks++;
        if (exp_q.size() != 0) begin
          fails++;
          $display("FAIL missing_events: got %0d expected events never seen, required 0 (first: dut%0d kind=%0d data=%h cyc=%0d)",
                   exp_q.size(), exp_q[0].d, exp_q[0].kind, exp_q[0].data, exp_q[0].cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 3'b000;
    hs    = 3'b000;
    vs    = 3'b000;
    for (int d = 0; d < 3; d++) din[d] = 8'h00;
    repeat (3) @(posedge pclk);
    #1;
    rst_n = 3'b111;
    idle(0, 2);

    // dut 0: bytes before any frame sync are ignored
    drv(0, 1'b1, 1'b0, 8'h99);
    drv(0, 1'b1, 1'b0, 8'h99);
    drv(0, 1'b1, 1'b0, 8'h99);
    idle(0, 2);
    vs_pulse(0);
    drv(0, 1'b1, 1'b0, 8'h11);
    drv(0, 1'b1, 1'b0, 8'h22);
    exp_pix(0, 32'h00112233, 0, 0, 1'b1);
    drv(0, 1'b1, 1'b0, 8'h33);
    exp_err(0, K_ELINE);               // 1 of 640 pixels
    idle(0, 3);
    drv(0, 1'b1, 1'b0, 8'h44);
    drv(0, 1'b1, 1'b0, 8'h55);
    exp_pix(0, 32'h00445566, 0, 1, 1'b0);
    drv(0, 1'b1, 1'b0, 8'h66);
    exp_err(0, K_ELINE);
    idle(0, 2);
    exp_err(0, K_EFRAME);              // only 2 of 480 lines
    vs_pulse(0);
    drv(0, 1'b1, 1'b0, 8'h77);
    drv(0, 1'b1, 1'b0, 8'h88);
    exp_pix(0, 32'h00778899, 0, 0, 1'b1);
    drv(0, 1'b1, 1'b0, 8'h99);
    exp_err(0, K_ELINE);
    idle(0, 4);

    // dut 1: first channel lands in the LSBs
    vs_pulse(1);
    drv(1, 1'b1, 1'b0, 8'h11);
    drv(1, 1'b1, 1'b0, 8'h22);
    exp_pix(1, 32'h00332211, 0, 0, 1'b1);
    drv(1, 1'b1, 1'b0, 8'h33);
    drv(1, 1'b1, 1'b0, 8'h44);
    drv(1, 1'b1, 1'b0, 8'h55);
    // reset mid-line, then a full line before any frame sync: no output
    rst_n[1] = 1'b0;
    drv(1, 1'b1, 1'b0, 8'h66);
    drv(1, 1'b1, 1'b0, 8'h77);
    rst_n[1] = 1'b1;
    for (int i = 0; i < 12; i++) drv(1, 1'b1, 1'b0, 8'(8'hC0 + i));
    idle(1, 3);
    vs_pulse(1);
    // 13 bytes: 4 pixels, trailing partial pixel
    tbl[0] = 32'h00030201; tbl[1] = 32'h00060504;
    tbl[2] = 32'h00090807; tbl[3] = 32'h000C0B0A;
    send_line(1, 13, 8'h01, 3, 4, 0);
    exp_err(1, K_ELINE);
    idle(1, 2);
    // 15 bytes: 5th complete pixel is beyond IW and dropped
    tbl[0] = 32'h00232221; tbl[1] = 32'h00262524;
    tbl[2] = 32'h00292827; tbl[3] = 32'h002C2B2A;
    send_line(1, 15, 8'h21, 3, 4, 1);
    exp_err(1, K_ELINE);
    idle(1, 2);
    // third line in a 2-line frame is dropped
    send_line(1, 12, 8'h41, 3, 0, 2);
    exp_err(1, K_EFRAME);
    idle(1, 2);
    vs_pulse(1);                       // complete frame: no error
    tbl[0] = 32'h00636261; tbl[1] = 32'h00666564;
    tbl[2] = 32'h00696867; tbl[3] = 32'h006C6B6A;
    send_line(1, 12, 8'h61, 3, 4, 0);
    idle(1, 2);                        // full line: no error
    // frame sync after one line, coinciding with a byte that is discarded
    exp_err(1, K_EFRAME);
    drv(1, 1'b1, 1'b1, 8'hEE);
    drv(1, 1'b1, 1'b1, 8'hA1);
    drv(1, 1'b1, 1'b1, 8'hA2);
    exp_pix(1, 32'h00A3A2A1, 0, 0, 1'b1);
    drv(1, 1'b1, 1'b1, 8'hA3);
    exp_err(1, K_ELINE);
    drv(1, 1'b0, 1'b1, 8'h00);
    drv(1, 1'b0, 1'b0, 8'h00);
    idle(1, 3);

    // dut 2: single channel pass-through, full clean frame
    vs_pulse(2);
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 4; x++) begin
        exp_pix(2, 32'(y * 4 + x + 1), x, y, (x == 0) && (y == 0));
        drv(2, 1'b1, 1'b0, 8'(y * 4 + x + 1));
      end
      idle(2, 2);
    end
    vs_pulse(2);
    idle(2, 4);

    done = 1'b1;
  end

endmodule

// File: doc/vedio_cap_pack.md
VEDIO_CAP_PACK -- requirements
Module: vedio_cap_pack

Interface
REQ-001 The block SHALL have parameter IW, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter IH, default 480, meaning active lines per frame.
REQ-003 The block SHALL have parameter SRC_DW, default 8, meaning width of one source channel byte.
REQ-004 The block SHALL have parameter SRC_CHN, default 3, meaning channels per pixel; legal range 1..4.
REQ-005 The block SHALL have parameter CHN_ORDER, default 0, meaning 0 = first-received channel in MSBs, 1 = first-received channel in LSBs.
REQ-006 The block SHALL derive localparam CAP_DW = SRC_DW*SRC_CHN, XW = clog2(IW+1) and YW = clog2(IH+1).
REQ-007 pclk  input  1  pixel clock; the only clock; all logic on its rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 src_hsync  input  1  source data-valid; high while a channel byte is present.
REQ-010 src_vsync  input  1  source field sync, active high; rising edge marks a frame boundary.
REQ-011 src_data_out  input  SRC_DW  source channel byte.
REQ-012 cap_hsync  output  1  one-cycle strobe per packed pixel.
REQ-013 cap_vsync  output  1  src_vsync delayed by one pclk.
REQ-014 cap_data_out  output  CAP_DW  packed pixel, valid with cap_hsync.
REQ-015 cap_x  output  XW  column of the current pixel (0..IW-1), valid with cap_hsync.
REQ-016 cap_y  output  YW  row of the current pixel (0..IH-1), valid with cap_hsync.
REQ-017 cap_sof  output  1  high with cap_hsync on pixel (0,0) only.
REQ-018 err_line  output  1  one-cycle pulse on a malformed line.
REQ-019 err_frame  output  1  one-cycle pulse on a malformed frame.

Function
REQ-020 The block SHALL run an FSM: S_SYNC (after reset, discard everything until the first src_vsync rising edge) -> S_ACTIVE; S_ACTIVE stays there and re-arms on each src_vsync rising edge.
REQ-021 In S_ACTIVE, each pclk with src_hsync=1 SHALL store one byte and increment chn_cnt (0..SRC_CHN-1, wrapping).
REQ-022 On the byte with chn_cnt=SRC_CHN-1, the next cycle SHALL drive cap_hsync=1 with the packed word: 1-cycle latency from the last channel byte.
REQ-023 With SRC_CHN=1, every valid byte SHALL appear on the next cycle unchanged: pass-through with 1-cycle latency.
REQ-024 Pixels with x_cnt >= IW SHALL be dropped (cap_hsync stays 0) and SHALL flag the line as erroneous.
REQ-025 On a src_hsync falling edge, the block SHALL pulse err_line the next cycle if chn_cnt != 0 (the partial pixel is discarded) or x_cnt != IW; it SHALL then clear x_cnt and chn_cnt and increment y_cnt, saturating at IH.
REQ-026 Lines arriving when y_cnt = IH SHALL be dropped, and err_frame SHALL pulse at that line's falling edge.
REQ-027 On a src_vsync rising edge in S_ACTIVE, the block SHALL pulse err_frame if y_cnt != IH, then clear x_cnt, y_cnt and chn_cnt.
REQ-028 If a src_vsync rising edge coincides with src_hsync=1, the frame clear SHALL take priority and the byte SHALL be discarded.
REQ-029 cap_vsync SHALL be registered src_vsync, so it stays aligned with the 1-cycle data latency.

Reset
REQ-030 While rst_n=0, the block SHALL drive all outputs to 0 and clear all counters and edge-detect registers.
REQ-031 Reset SHALL force the FSM to S_SYNC, including when asserted mid-line or mid-frame.

Structure
REQ-032 A shared package vedio_pkg SHALL hold the FSM state enum, the CHN_ORDER encodings and the clog2-based width helpers.
REQ-033 The block SHALL contain one sub-module, vedio_edge_det (registered rise/fall detect), instantiated for src_hsync and src_vsync.

Verification
REQ-034 Defaults, vsync rise, then bytes 0x11,0x22,0x33 -> one cap_hsync with 0x112233 at x=0, y=0, cap_sof=1, one cycle after 0x33.
REQ-035 CHN_ORDER=1, same bytes -> 0x332211.
REQ-036 SRC_CHN=1, IW=4, IH=2, full frame of bytes 1..8 -> 8 strobes carrying 1..8 with 1-cycle latency, no error pulses.
REQ-037 IW=4, line of 13 bytes with SRC_CHN=3 -> 4 pixels output, 5th dropped, err_line pulses once.
REQ-038 IH=2, vsync rise after 1 line -> err_frame pulse; next frame's first pixel has y=0.
REQ-039 Assert rst_n low mid-line, release, feed a line before any vsync -> no cap_hsync until the next vsync rise.
